regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the register file's single write port between the in-order writeback stage and the long-latency unit (multiply/divide). Writeback traffic has fixed priority and passes through in zero cycles. Long-latency results are buffered in a small FIFO and committed in idle write-port cycles. The block also keeps a pending-destination scoreboard for decode hazard stalls, and a starvation counter that forces a writeback bubble.

## Interface
Parameters:
- XLEN, 32, data width
- FIFO_DEPTH, 2, long-latency result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive blocked cycles before stall_out asserts (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- wb_regWrite_in  in  1  writeback stage write enable
- wb_rd_addr_in  in  5  writeback destination
- wb_write_data_in  in  XLEN  writeback data
- issue_valid_in  in  1  long-latency op issued this cycle
- issue_rd_addr_in  in  5  its destination
- lu_valid_in  in  1  long-latency result valid
- lu_rd_addr_in  in  5  result destination
- lu_data_in  in  XLEN  result data
- lu_ready_out  out  1  result accepted when valid&ready
- rf_we_out  out  1  register file write enable
- rf_rd_addr_out  out  5  register file write address
- rf_wd_out  out  XLEN  register file write data
- pending_mask_out  out  32  bit r set = register r awaiting long-latency result
- stall_out  out  1  request: freeze MEM/WB, insert writeback bubble

## Operation
- wb_req = wb_regWrite_in & (wb_rd_addr_in != 0). lu_head = FIFO non-empty.
- Grant: if wb_req, the port drives the wb fields. Else, if lu_head, the port drives the FIFO head and pops it. Else rf_we_out = 0, address/data = 0.
- A write to x0 never asserts rf_we_out. Results with rd 0 are accepted and popped without a write.
- FIFO push on lu_valid_in & lu_ready_out. lu_ready_out = !full, from the registered count only; there is no same-cycle ready from a pop.
- Scoreboard: issue_valid_in with rd≠0 sets bit rd. A FIFO pop clears bit rd. If a set and a clear hit the same rd in the same cycle, the set wins. Bit 0 is always 0.
- Starvation: blocked = lu_head & wb_req. starve_cnt increments on blocked, saturating at STARVE_LIMIT. It resets to 0 on any pop or when the FIFO is empty. stall_out = (starve_cnt == STARVE_LIMIT).
- While stall_out is high, the pipeline guarantees wb_regWrite_in = 0, so the head commits that cycle. If wb_req still arrives, writeback still wins; there is no data loss and the stall persists.
- A wb write and a pending bit for the same rd do not interact. Decode stalls on pending_mask_out, so this case is illegal upstream.

## Timing
- Write port: combinational from inputs and FIFO head, with zero-cycle latency for writeback.
- Long-latency result: accepted at edge N, written at the earliest in cycle N+1. It may be delayed by wb traffic until stall_out forces a bubble.
- Worst case from push to commit at the head of an empty FIFO: STARVE_LIMIT+1 cycles.
- Reset values: FIFO empty, starve_cnt 0, pending_mask_out 0, stall_out 0, lu_ready_out 1, rf_we_out 0 (when wb_regWrite_in = 0).
- Reset mid-operation discards FIFO contents and the scoreboard immediately. No partial write occurs after rst rises.
- Full FIFO plus simultaneous pop: lu_ready_out stays 0 that cycle and the count drops by 1.
- Pointers wrap modulo FIFO_DEPTH. The count is kept in log2(FIFO_DEPTH)+1 bits.

## Structure
- Shared package rf_arb_pkg: XLEN, REG_ADDR_W = 5, NUM_REGS = 32, and the lu_entry_t struct {rd, data}.
- One sub-module: wb_result_fifo (synchronous FIFO with async reset, push/pop/full/empty/head).
- Arbitration, scoreboard, and starvation counter live in the top module.

## Test plan
- wb write rd=5, data 0xDEADBEEF, with the FIFO empty → same cycle rf_we_out=1, addr 5, data 0xDEADBEEF. lu_ready_out stays 1.
- Issue rd=7, then a 1-cycle LU result rd=7, data 0x12 with no wb traffic → pending bit 7 is 1 until the next cycle. rf_we_out=1, addr 7, data 0x12, then bit 7 clears.
- Hold wb_req high continuously with one queued result, STARVE_LIMIT=4 → stall_out rises after 4 blocked cycles. When wb drops, the head commits and stall_out falls the next cycle.
- Push 2 results, then a third valid while wb_req is high → lu_ready_out=0. The third is accepted only after a pop, and commit order is preserved.
- Issue rd=3 in the same cycle as the pop of an old rd=3 result → the write occurs and pending bit 3 remains 1. Issue or results for rd=0 → no rf write and bit 0 stays 0.
- Assert rst with 2 queued entries and pending bits set → all outputs take their reset values asynchronously, and no write occurs after release.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared widths and the buffered long-latency result entry for the register file write arbiter.
package rf_arb_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } lu_entry_t;
endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous result FIFO; head visible combinationally the cycle after push.
// Push is ignored when full, pop is ignored when empty; full/empty come from the registered count.
module wb_result_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  lu_entry_t push_dat_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output lu_entry_t head_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  lu_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the RF write port: writeback wins in zero cycles, long-latency results drain from a FIFO
// in idle cycles. lu_ready_out is !full (registered); stall_out forces a writeback bubble on starvation.
module regfile_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int XLEN         = rf_arb_pkg::XLEN,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_regWrite_in,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr_in,
  input  logic [XLEN-1:0]       wb_write_data_in,
  input  logic                  issue_valid_in,
  input  logic [REG_ADDR_W-1:0] issue_rd_addr_in,
  input  logic                  lu_valid_in,
  input  logic [REG_ADDR_W-1:0] lu_rd_addr_in,
  input  logic [XLEN-1:0]       lu_data_in,
  output logic                  lu_ready_out,
  output logic                  rf_we_out,
  output logic [REG_ADDR_W-1:0] rf_rd_addr_out,
  output logic [XLEN-1:0]       rf_wd_out,
  output logic [NUM_REGS-1:0]   pending_mask_out,
  output logic                  stall_out
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  lu_entry_t           push_ent, head_ent;
  logic                fifo_full, fifo_empty;
  logic                wb_req, lu_head, pop, blocked;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [SW-1:0]       starve_q, starve_d;

  assign push_ent.rd   = lu_rd_addr_in;
  assign push_ent.data = lu_data_in;

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (lu_valid_in),
    .push_dat_i (push_ent),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (head_ent)
  );

  assign wb_req       = wb_regWrite_in & (wb_rd_addr_in != '0);
  assign lu_head      = ~fifo_empty;
  assign pop          = lu_head & ~wb_req;
  assign blocked      = lu_head & wb_req;
  assign lu_ready_out = ~fifo_full;

  always_comb begin
    rf_we_out      = 1'b0;
    rf_rd_addr_out = '0;
    rf_wd_out      = '0;
    if (wb_req) begin
      rf_we_out      = 1'b1;
      rf_rd_addr_out = wb_rd_addr_in;
      rf_wd_out      = wb_write_data_in;
    end else if (pop && head_ent.rd != '0) begin
      rf_we_out      = 1'b1;
      rf_rd_addr_out = head_ent.rd;
      rf_wd_out      = head_ent.data;
    end
  end

  // Issue is applied after the pop clear so a same-rd collision leaves the bit set.
  always_comb begin
    pending_d = pending_q;
    if (pop) pending_d[head_ent.rd] = 1'b0;
    if (issue_valid_in && issue_rd_addr_in != '0) pending_d[issue_rd_addr_in] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) starve_d = '0;
    else if (blocked && starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      starve_q  <= '0;
    end else begin
      pending_q <= pending_d;
      starve_q  <= starve_d;
    end
  end

  assign pending_mask_out = pending_q;
  assign stall_out        = (starve_q == STARVE_MAX);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed vector bench for regfile_write_arbiter (FIFO_DEPTH 2, STARVE_LIMIT 4).
module tb_regfile_write_arbiter;
  logic        clk, rst;
  logic        wb_regWrite_in, issue_valid_in, lu_valid_in;
  logic [4:0]  wb_rd_addr_in, issue_rd_addr_in, lu_rd_addr_in;
  logic [31:0] wb_write_data_in, lu_data_in;
  logic        lu_ready_out, rf_we_out, stall_out;
  logic [4:0]  rf_rd_addr_out;
  logic [31:0] rf_wd_out, pending_mask_out;

  int pass_cnt = 0;
  int total_cnt = 0;

  regfile_write_arbiter #(.XLEN(32), .FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .wb_regWrite_in   (wb_regWrite_in),
    .wb_rd_addr_in    (wb_rd_addr_in),
    .wb_write_data_in (wb_write_data_in),
    .issue_valid_in   (issue_valid_in),
    .issue_rd_addr_in (issue_rd_addr_in),
    .lu_valid_in      (lu_valid_in),
    .lu_rd_addr_in    (lu_rd_addr_in),
    .lu_data_in       (lu_data_in),
    .lu_ready_out     (lu_ready_out),
    .rf_we_out        (rf_we_out),
    .rf_rd_addr_out   (rf_rd_addr_out),
    .rf_wd_out        (rf_wd_out),
    .pending_mask_out (pending_mask_out),
    .stall_out        (stall_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_dat;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic        lu_v;
    logic [4:0]  lu_rd;
    logic [31:0] lu_dat;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_dat;
    logic        e_rdy;
    logic        e_stall;
    logic [31:0] e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic wb_we, logic [4:0] wb_rd, logic [31:0] wb_dat,
                             logic iss_v, logic [4:0] iss_rd,
                             logic lu_v, logic [4:0] lu_rd, logic [31:0] lu_dat,
                             logic e_we, logic [4:0] e_addr, logic [31:0] e_dat,
                             logic e_rdy, logic e_stall, logic [31:0] e_pend);
    vec_t r;
    r.wb_we = wb_we;   r.wb_rd = wb_rd;   r.wb_dat = wb_dat;
    r.iss_v = iss_v;   r.iss_rd = iss_rd;
    r.lu_v = lu_v;     r.lu_rd = lu_rd;   r.lu_dat = lu_dat;
    r.e_we = e_we;     r.e_addr = e_addr; r.e_dat = e_dat;
    r.e_rdy = e_rdy;   r.e_stall = e_stall; r.e_pend = e_pend;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic drive(input logic wb_we, input logic [4:0] wb_rd, input logic [31:0] wb_dat,
                       input logic iss_v, input logic [4:0] iss_rd,
                       input logic lu_v, input logic [4:0] lu_rd, input logic [31:0] lu_dat);
    wb_regWrite_in = wb_we; wb_rd_addr_in = wb_rd; wb_write_data_in = wb_dat;
    issue_valid_in = iss_v; issue_rd_addr_in = iss_rd;
    lu_valid_in = lu_v; lu_rd_addr_in = lu_rd; lu_data_in = lu_dat;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Each vector is one cycle; outputs are checked before the rising edge.
    //          wb_we rd  data          iss rd  lu rd  data        we addr data        rdy stl pend
    vecs.push_back(v(0, 0,  32'h0,        0, 0,  0, 0,  32'h0,      0, 0,  32'h0,        1, 0, 32'h0));   // 0 idle
    vecs.push_back(v(1, 5,  32'hDEADBEEF, 0, 0,  0, 0,  32'h0,      1, 5,  32'hDEADBEEF, 1, 0, 32'h0));   // 1 wb passthrough
    vecs.push_back(v(0, 0,  32'h0,        1, 7,  0, 0,  32'h0,      0, 0,  32'h0,        1, 0, 32'h0));   // 2 issue rd7
    vecs.push_back(v(0, 0,  32'h0,        0, 0,  1, 7,  32'h12,     0, 0,  32'h0,        1, 0, 32'h80));  // 3 result rd7
    vecs.push_back(v(0, 0,  32'h0,        0, 0,  0, 0,  32'h0,      1, 7,  32'h12,       1, 0, 32'h80));  // 4 commit rd7
    vecs.push_back(v(0, 0,  32'h0,        0, 0,  0, 0,  32'h0,      0, 0,  32'h0,        1, 0, 32'h0));   // 5 bit7 cleared
    vecs.push_back(v(0, 0,  32'h0,        1, 9,  1, 9,  32'h99,     0, 0,  32'h0,        1, 0, 32'h0));   // 6 issue+result rd9
    vecs.push_back(v(1, 1,  32'h11,       0, 0,  0, 0,  32'h0,      1, 1,  32'h11,       1, 0, 32'h200)); // 7 blocked 1
    vecs.push_back(v(1, 1,  32'h11,       0, 0,  0, 0,  32'h0,      1, 1,  32'h11,       1, 0, 32'h200)); // 8 blocked 2
    vecs.push_back(v(1, 1,  32'h11,       0, 0,  0, 0,  32'h0,      1, 1,  32'h11,       1, 0, 32'h200)); // 9 blocked 3
    vecs.push_back(v(1, 1,  32'h11,       0, 0,  0, 0,  32'h0,      1, 1,  32'h11,       1, 0, 32'h200)); // 10 blocked 4
    vecs.push_back(v(1, 1,  32'h11,       0, 0,  0, 0,  32'h0,      1, 1,  32'h11,       1, 1, 32'h200)); // 11 stall, wb wins
    vecs.push_back(v(0, 0,  32'h0,        0, 0,  0, 0,  32'h0,      1, 9,  32'h99,       1, 1, 32'h200)); // 12 bubble commits
    vecs.push_back(v(0, 0,  32'h0,        0, 0,  0, 0,  32'h0,      0, 0,  32'h0,        1, 0, 32'h0));   // 13 stall falls
    vecs.push_back(v(1, 2,  32'h22,       0, 0,  1, 10, 32'hA0,     1, 2,  32'h22,       1, 0, 32'h0));   // 14 push A
    vecs.push_back(v(1, 2,  32'h23,       0, 0,  1, 11, 32'hB1,     1, 2,  32'h23,       1, 0, 32'h0));   // 15 push B
    vecs.push_back(v(1, 2,  32'h24,       0, 0,  1, 12, 32'hC2,     1, 2,  32'h24,       0, 0, 32'h0));   // 16 full, C refused
    vecs.push_back(v(0, 0,  32'h0,        0, 0,  1, 12, 32'hC2,     1, 10, 32'hA0,       0, 0, 32'h0));   // 17 pop while full
    vecs.push_back(v(0, 0,  32'h0,        0, 0,  1, 12, 32'hC2,     1, 11, 32'hB1,       1, 0, 32'h0));   // 18 C accepted
    vecs.push_back(v(0, 0,  32'h0,        0, 0,  0, 0,  32'h0,      1, 12, 32'hC2,       1, 0, 32'h0));   // 19 C commits
    vecs.push_back(v(0, 0,  32'h0,        0, 0,  0, 0,  32'h0,      0, 0,  32'h0,        1, 0, 32'h0));   // 20 empty
    vecs.push_back(v(0, 0,  32'h0,        1, 3,  1, 3,  32'h33,     0, 0,  32'h0,        1, 0, 32'h0));   // 21 issue+result rd3
    vecs.push_back(v(0, 0,  32'h0,        1, 3,  0, 0,  32'h0,      1, 3,  32'h33,       1, 0, 32'h8));   // 22 re-issue rd3 on pop
    vecs.push_back(v(1, 0,  32'h55,       1, 0,  1, 0,  32'h77,     0, 0,  32'h0,        1, 0, 32'h8));   // 23 x0 traffic
    vecs.push_back(v(0, 0,  32'h0,        0, 0,  0, 0,  32'h0,      0, 0,  32'h0,        1, 0, 32'h8));   // 24 rd0 pops silently
    vecs.push_back(v(0, 0,  32'h0,        0, 0,  0, 0,  32'h0,      0, 0,  32'h0,        1, 0, 32'h8));   // 25 bit3 held

    #12;
    chk("reset rdy", lu_ready_out, 1);
    chk("reset stall", stall_out, 0);
    chk("reset pend", pending_mask_out, 0);
    chk("reset we", rf_we_out, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].wb_we, vecs[i].wb_rd, vecs[i].wb_dat, vecs[i].iss_v, vecs[i].iss_rd,
            vecs[i].lu_v, vecs[i].lu_rd, vecs[i].lu_dat);
      #1;
      chk($sformatf("v%0d we", i), rf_we_out, vecs[i].e_we);
      chk($sformatf("v%0d addr", i), rf_rd_addr_out, vecs[i].e_addr);
      chk($sformatf("v%0d data", i), rf_wd_out, vecs[i].e_dat);
      chk($sformatf("v%0d rdy", i), lu_ready_out, vecs[i].e_rdy);
      chk($sformatf("v%0d stall", i), stall_out, vecs[i].e_stall);
      chk($sformatf("v%0d pend", i), pending_mask_out, vecs[i].e_pend);
    end

    // Fill the FIFO behind writeback traffic, then reset mid-cycle.
    @(negedge clk);
    drive(1, 1, 32'h1, 1, 4, 1, 4, 32'h44);
    @(negedge clk);
    drive(1, 1, 32'h1, 1, 5, 1, 5, 32'h55);
    @(negedge clk);
    drive(1, 1, 32'h1, 0, 0, 0, 0, 32'h0);
    #1;
    chk("pre-rst rdy", lu_ready_out, 0);
    chk("pre-rst pend", pending_mask_out, 32'h38);
    #1;
    rst = 1'b1;
    wb_regWrite_in = 1'b0;
    #1;
    chk("async rst rdy", lu_ready_out, 1);
    chk("async rst stall", stall_out, 0);
    chk("async rst pend", pending_mask_out, 0);
    chk("async rst we", rf_we_out, 0);
    chk("async rst addr", rf_rd_addr_out, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("post-rst%0d we", k), rf_we_out, 0);
      chk($sformatf("post-rst%0d pend", k), pending_mask_out, 0);
      chk($sformatf("post-rst%0d rdy", k), lu_ready_out, 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
